burst_frame_tx: RTL and testbench
=================================

// Module: burst_frame_tx
// PURPOSE
// Transmit side of the valid-burst sample interface consumed by our trimmed-sum receivers.
// Buffers one frame of 8-bit samples from an upstream ready/valid source, then replays it
// as one contiguous tx_vld burst followed by a guaranteed idle gap, which is the receiver's frame delimiter.
// Also computes the expected trimmed sum (sum - max - min) of each frame for in-system self-check.
// PARAMETERS
// DATA_W     8   sample width; fixed at 8 in this revision
// FRAME_LEN  8   maximum samples per frame, 2..256
// GAP_CYC    2   minimum idle cycles (tx_vld=0) after each burst, >=1
// PORTS
// clk        in   1   clock, rising edge
// rst_n      in   1   reset, asynchronous, active-low
// s_data     in   8   upstream sample
// s_valid    in   1   upstream sample valid
// s_last     in   1   marks the final sample of a short frame; qualified by s_valid&s_ready
// s_ready    out  1   block accepts s_data this cycle
// tx_data    out  8   burst sample to receiver
// tx_vld     out  1   burst valid, high for exactly n consecutive cycles per frame
// exp_sum    out  16  expected trimmed sum of the frame just sent
// exp_vld    out  1   one-cycle strobe qualifying exp_sum
// busy       out  1   high in SEND and GAP
// frame_cnt  out  16  frames completed, wraps 0xFFFF->0
// BEHAVIOUR
// - Reset (async, any state): state=FILL, fill count=0, all outputs 0 except s_ready=1; buffer contents don't-care.
// - All outputs are registered except s_ready, which is decoded from state (1 only in FILL).
// - FILL: each s_valid&s_ready stores s_data at buffer[count], count++; running sum/max/min update.
//   Frame closes on the accepting beat when count+1==FRAME_LEN or s_last=1 (both at once: one frame).
//   s_last without s_valid is ignored. Empty frames cannot occur.
// - SEND: entered the cycle after the closing handshake; tx_data=buffer[i], tx_vld=1 for i=0..n-1,
//   no bubbles. First tx beat appears 1 cycle after the closing handshake.
// - On the last SEND beat: exp_vld=1 and exp_sum valid in the same cycle as the final tx_vld.
// - GAP: tx_vld=0, tx_data=0 for exactly GAP_CYC cycles; frame_cnt increments on GAP entry; then FILL, count=0.
// - Outside SEND, tx_data=0 and tx_vld=0; exp_sum holds its last value, exp_vld=0.
// - Arithmetic: running sum is 16 bits, zero-extended adds; max of FRAME_LEN*255 fits, no overflow.
//   max init 0x00, min init 0xFF at frame start; first sample loads both.
//   n>=3: exp_sum = sum - max - min (one instance each removed even if duplicated);
//   n==1 or n==2: exp_sum=0.
// - Upstream backpressure: s_ready=0 for the n+GAP_CYC cycles of SEND+GAP; source must hold data.
// - Reset mid-SEND truncates the burst immediately; no exp_vld for that frame; frame_cnt=0.
// STRUCTURE
// - Shared package burst_pkg: DATA_W, SUM_W=16, state encodings FILL/SEND/GAP,
//   clog2 helper for the count width.
// - Sub-module frame_stats: running sum/max/min accumulator with clear, sample-enable, and 16-bit trimmed-result output;
//   reused by the receiver-side reference model.
// - Top level holds the FSM, the FRAME_LEN x 8 register buffer, the read index, and the gap counter.
// TESTING
// - Full frame 1,2,...,8 back-to-back s_valid -> tx_vld 8 cycles with 1..8, exp_sum=36-8-1=27, then 2 idle cycles.
// - s_last on 3rd of 5,9,7 -> 3-beat burst, exp_sum=7; s_ready low for 3+2 cycles.
// - Duplicates 4,4,4,4 (s_last on 4th) -> exp_sum=8; single sample 0xFF with s_last -> exp_sum=0.
// - Eight samples 0xFF -> exp_sum=0x05FA; no overflow; frame_cnt increments by 1 per frame.
// - Random s_valid gaps during FILL -> burst still contiguous; sample order preserved.
// - rst_n low on 2nd SEND beat -> tx_vld=0 at once, no exp_vld; next frame sends correctly.

Source files
------------

// File: rtl/burst_pkg.sv
// Shared definitions for the burst transmit path and its receiver-side models.
//   DATA_W  : sample width (fixed at 8)
//   SUM_W   : running / trimmed sum width
//   state_e : FILL / SEND / GAP transmit FSM states
//   clog2   : width helper for counters and indices
package burst_pkg;

  localparam int DATA_W = 8;
  localparam int SUM_W  = 16;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/frame_stats.sv
// Running sum / max / min accumulator for one frame of samples.
//   clk, rst_n : clock, async active-low reset
//   clr        : start a new frame (a same-cycle en starts it with din)
//   en         : accumulate din
//   din        : sample
//   trim       : sum - max - min once >=3 samples seen, else 0
module frame_stats
  import burst_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [SUM_W-1:0]  trim
);

  logic [SUM_W-1:0]  sum_q, sum_d, sum_b;
  logic [DATA_W-1:0] max_q, max_d, max_b;
  logic [DATA_W-1:0] min_q, min_d, min_b;
  // sample count saturates at 3; only "fewer than three" matters
  logic [1:0]        n_q, n_d, n_b;

  always_comb begin
    sum_b = clr ? '0 : sum_q;
    max_b = clr ? '0 : max_q;
    min_b = clr ? '1 : min_q;
    n_b   = clr ? '0 : n_q;
    sum_d = sum_b;
    max_d = max_b;
    min_d = min_b;
    n_d   = n_b;
    if (en) begin
      sum_d = sum_b + {{(SUM_W-DATA_W){1'b0}}, din};
      max_d = (din > max_b) ? din : max_b;
      min_d = (din < min_b) ? din : min_b;
      n_d   = (n_b == 2'd3) ? 2'd3 : n_b + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      max_q <= '0;
      min_q <= '1;
      n_q   <= '0;
    end else begin
      sum_q <= sum_d;
      max_q <= max_d;
      min_q <= min_d;
      n_q   <= n_d;
    end
  end

  assign trim = (n_q == 2'd3)
              ? sum_q - {{(SUM_W-DATA_W){1'b0}}, max_q} - {{(SUM_W-DATA_W){1'b0}}, min_q}
              : '0;

endmodule

// File: rtl/burst_frame_tx.sv
// Buffers one frame from a ready/valid source, replays it as a contiguous
// tx_vld burst followed by GAP_CYC idle cycles, and reports the frame's
// trimmed sum alongside the final burst beat.
//   s_data/s_valid/s_last/s_ready : upstream sample stream (ready only in FILL)
//   tx_data/tx_vld                : burst to receiver
//   exp_sum/exp_vld               : trimmed sum, strobed with the last beat
//   busy                          : SEND or GAP
//   frame_cnt                     : frames completed (wrapping)
module burst_frame_tx
  import burst_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int GAP_CYC   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  output logic [DATA_W-1:0]   tx_data,
  output logic                tx_vld,
  output logic [SUM_W-1:0]    exp_sum,
  output logic                exp_vld,
  output logic                busy,
  output logic [15:0]         frame_cnt
);

  localparam int IDX_W = clog2(FRAME_LEN);
  localparam int CNT_W = clog2(FRAME_LEN + 1);
  localparam int GAP_W = clog2(GAP_CYC + 1);
  localparam logic [CNT_W-1:0] LEN_M1   = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  state_e                                state_q, state_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic [CNT_W-1:0]                      n_q, n_d;
  logic [CNT_W-1:0]                      idx_q, idx_d, nxt_idx;
  logic [GAP_W-1:0]                      gap_q, gap_d;
  logic [FRAME_LEN-1:0][DATA_W-1:0]      buf_q, buf_d;
  logic [DATA_W-1:0]                     tx_data_q, tx_data_d;
  logic                                  tx_vld_q, tx_vld_d;
  logic [SUM_W-1:0]                      exp_sum_q, exp_sum_d;
  logic                                  exp_vld_q, exp_vld_d;
  logic                                  busy_q, busy_d;
  logic [15:0]                           frame_cnt_q, frame_cnt_d;
  logic                                  acc, close, st_clr;
  logic [SUM_W-1:0]                      trim;

  assign s_ready = (state_q == ST_FILL);
  assign acc     = s_valid & s_ready;
  assign close   = acc & (s_last | (cnt_q == LEN_M1));
  assign nxt_idx = idx_q + ONE;

  frame_stats u_stats (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (st_clr),
    .en    (acc),
    .din   (s_data),
    .trim  (trim)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    buf_d       = buf_q;
    tx_data_d   = '0;
    tx_vld_d    = 1'b0;
    exp_sum_d   = exp_sum_q;
    exp_vld_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    st_clr      = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (acc) begin
          buf_d[cnt_q[IDX_W-1:0]] = s_data;
          cnt_d = cnt_q + ONE;
          if (close) begin
            // beat 0 is launched on the closing edge so the burst starts
            // in the first SEND cycle; a 1-sample frame bypasses the buffer
            state_d   = ST_SEND;
            n_d       = cnt_q + ONE;
            idx_d     = '0;
            tx_vld_d  = 1'b1;
            tx_data_d = (cnt_q == '0) ? s_data : buf_q[0];
            if (cnt_q == '0) begin
              exp_vld_d = 1'b1;
              exp_sum_d = '0;
            end
          end
        end
      end
      ST_SEND: begin
        // idx_q is the beat currently on tx_data; load the next one
        if (nxt_idx < n_q) begin
          tx_vld_d  = 1'b1;
          tx_data_d = buf_q[nxt_idx[IDX_W-1:0]];
          idx_d     = nxt_idx;
          if (nxt_idx == n_q - ONE) begin
            exp_vld_d = 1'b1;
            exp_sum_d = trim;
          end
        end else begin
          state_d     = ST_GAP;
          gap_d       = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_FILL;
          cnt_d   = '0;
          st_clr  = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_FILL;
    endcase
    busy_d = (state_d != ST_FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      cnt_q       <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      gap_q       <= '0;
      tx_data_q   <= '0;
      tx_vld_q    <= 1'b0;
      exp_sum_q   <= '0;
      exp_vld_q   <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      tx_data_q   <= tx_data_d;
      tx_vld_q    <= tx_vld_d;
      exp_sum_q   <= exp_sum_d;
      exp_vld_q   <= exp_vld_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // sample storage needs no reset
  always_ff @(posedge clk) buf_q <= buf_d;

  assign tx_data   = tx_data_q;
  assign tx_vld    = tx_vld_q;
  assign exp_sum   = exp_sum_q;
  assign exp_vld   = exp_vld_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_burst_frame_tx.sv
module tb_burst_frame_tx;

  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid, s_last, s_ready;
  logic [7:0]  tx_data;
  logic        tx_vld, exp_vld, busy;
  logic [15:0] exp_sum, frame_cnt;

  int          checks = 0;
  int          errors = 0;
  int          fc     = 0;
  logic [7:0]  fq[$];

  always #5 clk = ~clk;

  burst_frame_tx #(.FRAME_LEN(8), .GAP_CYC(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .tx_data   (tx_data),
    .tx_vld    (tx_vld),
    .exp_sum   (exp_sum),
    .exp_vld   (exp_vld),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive fq as one frame; inputs change just after negedge, DUT samples at
  // posedge. Returns at the negedge following the closing handshake.
  task automatic push_frame(input bit use_last, input bit gaps);
    for (int i = 0; i < fq.size(); i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      chk("fill_ready", s_ready, 1);
      s_valid = 1'b1;
      s_data  = fq[i];
      s_last  = use_last && (i == fq.size() - 1);
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
  endtask

  // Starting in the first SEND cycle: check each beat, the strobe, the gap.
  task automatic expect_burst(input string tag, input logic [15:0] es);
    for (int i = 0; i < fq.size(); i++) begin
      chk({tag, "_vld"},   tx_vld, 1);
      chk({tag, "_data"},  tx_data, fq[i]);
      chk({tag, "_rdy"},   s_ready, 0);
      chk({tag, "_busy"},  busy, 1);
      chk({tag, "_evld"},  exp_vld, (i == fq.size() - 1) ? 1 : 0);
      if (i == fq.size() - 1) chk({tag, "_esum"}, exp_sum, es);
      @(negedge clk);
    end
    fc++;
    for (int g = 0; g < GAP; g++) begin
      chk({tag, "_gap_vld"},  tx_vld, 0);
      chk({tag, "_gap_data"}, tx_data, 0);
      chk({tag, "_gap_rdy"},  s_ready, 0);
      chk({tag, "_gap_evld"}, exp_vld, 0);
      chk({tag, "_gap_fcnt"}, frame_cnt, fc);
      @(negedge clk);
    end
    chk({tag, "_post_rdy"},  s_ready, 1);
    chk({tag, "_post_busy"}, busy, 0);
    chk({tag, "_post_esum"}, exp_sum, es);
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", s_ready, 1);
    chk("rst_txvld", tx_vld, 0);
    chk("rst_txdat", tx_data, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_fcnt",  frame_cnt, 0);
    chk("rst_evld",  exp_vld, 0);
    chk("rst_esum",  exp_sum, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // full frame closes on length
    fq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    push_frame(1'b0, 1'b0);
    expect_burst("full", 16'd27);

    // lone s_last is ignored, then short frame
    s_last = 1'b1;
    @(negedge clk);
    s_last = 1'b0;
    fq = '{8'd5, 8'd9, 8'd7};
    push_frame(1'b1, 1'b0);
    expect_burst("short", 16'd7);

    fq = '{8'd4, 8'd4, 8'd4, 8'd4};
    push_frame(1'b1, 1'b0);
    expect_burst("dup", 16'd8);

    fq = '{8'hFF};
    push_frame(1'b1, 1'b0);
    expect_burst("single", 16'd0);

    fq = '{8'd200, 8'd3};
    push_frame(1'b1, 1'b0);
    expect_burst("pair", 16'd0);

    fq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    push_frame(1'b0, 1'b0);
    expect_burst("allff", 16'h05FA);

    // gaps on s_valid; 10+20+..+80=360, -80-10 = 270
    fq = '{8'd30, 8'd10, 8'd80, 8'd20, 8'd50, 8'd40, 8'd70, 8'd60};
    push_frame(1'b0, 1'b1);
    expect_burst("gaps", 16'd270);

    // reset on the 2nd SEND beat
    fq = '{8'd11, 8'd22, 8'd33};
    push_frame(1'b1, 1'b0);
    chk("mid_beat0", tx_data, 11);
    @(negedge clk);
    chk("mid_beat1", tx_data, 22);
    rst_n = 1'b0;
    #1;
    chk("mid_txvld", tx_vld, 0);
    chk("mid_evld",  exp_vld, 0);
    chk("mid_fcnt",  frame_cnt, 0);
    chk("mid_ready", s_ready, 1);
    chk("mid_busy",  busy, 0);
    fc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_idle_vld", tx_vld, 0);

    fq = '{8'd9, 8'd1, 8'd5, 8'd3};
    push_frame(1'b1, 1'b0);
    expect_burst("after_rst", 16'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
